lane_deserializer: RTL



---
 rtl/lane_deserializer_if.sv | 29 ++
 rtl/lane_deserializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lane_deserializer_if.sv
// Bus bundle for lane_deserializer: serial lane inputs, slip/training controls,
// and the parallel word / training status outputs.
interface lane_deserializer_if #(
  parameter int LANES      = 8,
  parameter int IN_WIDTH   = 2,
  parameter int DATA_WIDTH = 8
);
  logic [LANES*IN_WIDTH-1:0]           i_din;
  logic [LANES-1:0]                    i_bitslip;
  logic                                i_train_start;
  logic [LANES*DATA_WIDTH-1:0]         o_data;
  logic                                o_valid;
  logic [LANES*$clog2(DATA_WIDTH)-1:0] o_slip_cnt;
  logic                                o_train_busy;
  logic                                o_train_done;
  logic [LANES-1:0]                    o_train_locked;
  logic                                o_train_error;

  modport master (
    output i_din, i_bitslip, i_train_start,
    input  o_data, o_valid, o_slip_cnt, o_train_busy, o_train_done,
           o_train_locked, o_train_error
  );
  modport slave (
    input  i_din, i_bitslip, i_train_start,
    output o_data, o_valid, o_slip_cnt, o_train_busy, o_train_done,
           o_train_locked, o_train_error
  );
endinterface

// File: rtl/lane_deserializer.sv
// Multi-lane serial-to-parallel deserializer with per-lane bitslip.
// Define AUTO_TRAIN_EN to build the word-alignment training FSM.
module lane_deserializer_lane #(
  parameter int IN_WIDTH   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int SW         = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [IN_WIDTH-1:0]   din,
  input  logic                  extract,
  input  logic                  slip,
  output logic [DATA_WIDTH-1:0] data,
  output logic [SW-1:0]         slip_cnt
);
  logic [2*DATA_WIDTH-1:0] hist_q, hist_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [SW-1:0]           slip_q, slip_d;

  always_comb begin
    hist_d = {hist_q[2*DATA_WIDTH-IN_WIDTH-1:0], din};
    data_d = data_q;
    slip_d = slip_q;
    // larger slip selects older bits, delaying the word window
    if (extract) data_d = DATA_WIDTH'(hist_d >> slip_q);
    if (slip)    slip_d = (slip_q == SW'(DATA_WIDTH-1)) ? '0 : slip_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist_q <= '0;
      data_q <= '0;
      slip_q <= '0;
    end else begin
      hist_q <= hist_d;
      data_q <= data_d;
      slip_q <= slip_d;
    end
  end

  assign data     = data_q;
  assign slip_cnt = slip_q;
endmodule

module lane_deserializer #(
  parameter int                    LANES         = 8,
  parameter int                    IN_WIDTH      = 2,
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 'h5A,
  parameter int                    SETTLE_WORDS  = 2
) (
  input logic              CLK,
  input logic              RST,
  lane_deserializer_if.slave bus
);
  localparam int RATIO = DATA_WIDTH / IN_WIDTH;
  localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int SW    = $clog2(DATA_WIDTH);

  logic [PW-1:0] phase_q, phase_d;
  logic          valid_q, valid_d;
  logic          extract;
  logic          train_busy;
  logic [LANES-1:0] fsm_slip, slip_req;
  logic [LANES-1:0][DATA_WIDTH-1:0] lane_data;
  logic [LANES-1:0][SW-1:0]         lane_slip;

  always_comb begin
    extract = (phase_q == PW'(RATIO-1));
    phase_d = extract ? '0 : phase_q + 1'b1;
    valid_d = extract;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase_q <= '0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  assign slip_req = (bus.i_bitslip & {LANES{~train_busy}}) | fsm_slip;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_deserializer_lane #(.IN_WIDTH(IN_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lane (
      .CLK      (CLK),
      .RST      (RST),
      .din      (bus.i_din[l*IN_WIDTH +: IN_WIDTH]),
      .extract  (extract),
      .slip     (slip_req[l]),
      .data     (lane_data[l]),
      .slip_cnt (lane_slip[l])
    );
  end

  assign bus.o_data     = lane_data;
  assign bus.o_slip_cnt = lane_slip;
  assign bus.o_valid    = valid_q;

`ifdef AUTO_TRAIN_EN
  localparam int AW = $clog2(DATA_WIDTH+1);
  localparam int CW = (SETTLE_WORDS > 0) ? $clog2(SETTLE_WORDS+1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_DONE} state_e;
  state_e           state_q, state_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic [AW-1:0]    attempt_q, attempt_d;
  logic [LANES-1:0] locked_q, locked_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    attempt_d = attempt_q;
    locked_d  = locked_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    fsm_slip  = '0;
    case (state_q)
      S_IDLE: if (bus.i_train_start) begin
        busy_d = 1'b1; locked_d = '0; error_d = 1'b0;
        attempt_d = '0; settle_d = '0; state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (SETTLE_WORDS == 0) state_d = S_CHECK;
        else if (valid_q) begin
          if (settle_q == CW'(SETTLE_WORDS-1)) state_d = S_CHECK;
          else settle_d = settle_q + 1'b1;
        end
      end
      S_CHECK: if (valid_q) begin
        for (int l = 0; l < LANES; l++)
          if (lane_data[l] == TRAIN_PATTERN) locked_d[l] = 1'b1;
        // locked lanes keep their slip for the rest of the run
        fsm_slip = ~locked_d;
        state_d  = S_SLIP;
      end
      S_SLIP: begin
        attempt_d = attempt_q + 1'b1;
        settle_d  = '0;
        if (&locked_q || attempt_d == AW'(DATA_WIDTH)) state_d = S_DONE;
        else state_d = S_SETTLE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        error_d = ~&locked_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE; settle_q <= '0; attempt_q <= '0; locked_q <= '0;
      busy_q  <= 1'b0;   done_q   <= 1'b0; error_q <= 1'b0;
    end else begin
      state_q <= state_d; settle_q <= settle_d; attempt_q <= attempt_d; locked_q <= locked_d;
      busy_q  <= busy_d;  done_q   <= done_d;   error_q   <= error_d;
    end
  end

  assign train_busy         = busy_q;
  assign bus.o_train_busy   = busy_q;
  assign bus.o_train_done   = done_q;
  assign bus.o_train_locked = locked_q;
  assign bus.o_train_error  = error_q;
`else
  logic [DATA_WIDTH:0] unused_cfg;
  assign unused_cfg = {bus.i_train_start, TRAIN_PATTERN} ^ (DATA_WIDTH+1)'(SETTLE_WORDS);

  assign train_busy         = 1'b0;
  assign fsm_slip           = '0;
  assign bus.o_train_busy   = 1'b0;
  assign bus.o_train_done   = 1'b0;
  assign bus.o_train_locked = '0;
  assign bus.o_train_error  = 1'b0;
`endif
endmodule
